// File: rtl/tt_bin_clock_btn_cond_if.sv
// Button-conditioner bus: raw buttons and repeat enable in, clean pulses and
// debounced levels out. Bit 2p+1 = increment, bit 2p = decrement for pair p.
interface tt_bin_clock_btn_cond_if #(
   parameter int NUM_PAIRS = 3
);
   logic [2*NUM_PAIRS-1:0] btn_i;
   logic                   rpt_en_i;
   logic [2*NUM_PAIRS-1:0] id_o;
   logic [2*NUM_PAIRS-1:0] stable_o;

   // Source of the buttons (board / testbench).
   modport master (
      output btn_i,
      output rpt_en_i,
      input  id_o,
      input  stable_o
   );

   // The conditioner itself.
   modport slave (
      input  btn_i,
      input  rpt_en_i,
      output id_o,
      output stable_o
   );
endinterface

// File: rtl/tt_bin_clock_btn_cond.sv
// Button conditioner for the binary clock core: synchronizes raw buttons,
// debounces them, and turns presses into single-cycle inc/dec pulses with
// optional auto-repeat. Both buttons of a pair held together cancel each other.
module tt_bin_clock_btn_cond #(
   parameter int NUM_PAIRS  = 3,
   parameter int DB_CNT     = 100000,
   parameter int RPT_DELAY  = 5000000,
   parameter int RPT_PERIOD = 1000000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   tt_bin_clock_btn_cond_if.slave  bus
);

   localparam int NB    = 2 * NUM_PAIRS;
   localparam int MAX_A = (DB_CNT > RPT_DELAY) ? DB_CNT : RPT_DELAY;
   localparam int MAX_P = (MAX_A > RPT_PERIOD) ? MAX_A : RPT_PERIOD;
   localparam int CW    = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] DB_LAST  = CW'(DB_CNT - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD - 1);

   logic [NB-1:0] s1_q, s1_d;
   logic [NB-1:0] s2_q, s2_d;
   logic [NB-1:0] stable_q, stable_d;
   logic [NB-1:0] id_q, id_d;
   logic [NB-1:0] phase_q, phase_d;      // 0 = waiting RPT_DELAY, 1 = repeating
   logic [CW-1:0] db_cnt_q [NB];
   logic [CW-1:0] db_cnt_d [NB];
   logic [CW-1:0] hold_q   [NB];
   logic [CW-1:0] hold_d   [NB];

   logic [NB-1:0] conf_cur;              // per bit: its pair is in conflict now
   logic [NB-1:0] conf_nxt;              // per bit: its pair conflicts after this edge
   logic [NB-1:0] rpt_act;
   logic [NB-1:0] rpt_fire;

   // Two-flop synchronizer feeding the debouncers.
   always_comb begin
      s1_d = bus.btn_i;
      s2_d = s1_q;
   end

   // Debounce: the stable level flips only after DB_CNT consecutive differing samples.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      stable_d = stable_q;
      for (int b = 0; b < NB; b++) begin
         db_cnt_d[b] = '0;
         if (s2_q[b] != stable_q[b]) begin
            if (db_cnt_q[b] == DB_LAST) begin
               stable_d[b] = s2_q[b];
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + 1'b1;
            end
         end
      end
   end

   // Pair conflict, both for the current and the upcoming debounced state.
   always_comb begin
      conf_cur = '0;
      conf_nxt = '0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
         conf_cur[2*p +: 2] = {2{&stable_q[2*p +: 2]}};
         conf_nxt[2*p +: 2] = {2{&stable_d[2*p +: 2]}};
      end
   end

   // Repeat qualification: held steadily, enabled, and no conflict on either side of the edge.
   always_comb begin
      rpt_act  = '0;
      rpt_fire = '0;
      for (int b = 0; b < NB; b++) begin
         rpt_act[b]  = bus.rpt_en_i & stable_q[b] & stable_d[b] & ~conf_cur[b] & ~conf_nxt[b];
         rpt_fire[b] = rpt_act[b] &
                       (phase_q[b] ? (hold_q[b] == PER_LAST) : (hold_q[b] == DLY_LAST));
      end
   end

   // Hold counters and output pulses; a press edge always sees rpt_act=0 and clears the counter.
   always_comb begin
      phase_d = phase_q;
      id_d    = '0;
      for (int b = 0; b < NB; b++) begin
         hold_d[b] = '0;
         if (rpt_fire[b]) begin
            phase_d[b] = 1'b1;
         end else if (rpt_act[b]) begin
            hold_d[b] = hold_q[b] + 1'b1;
         end else begin
            phase_d[b] = 1'b0;
         end
      end
      id_d = ((stable_d & ~stable_q) | rpt_fire) & ~conf_nxt;
   end

   // State register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         id_q     <= '0;
         phase_q  <= '0;
         // NOTE: these counter arrays are small flop banks, not RAM, so they are reset like any other state.
         for (int b = 0; b < NB; b++) begin
            db_cnt_q[b] <= '0;
            hold_q[b]   <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the pre-edge values computed above.
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         id_q     <= id_d;
         phase_q  <= phase_d;
         for (int b = 0; b < NB; b++) begin
            db_cnt_q[b] <= db_cnt_d[b];
            hold_q[b]   <= hold_d[b];
         end
      end
   end

   assign bus.id_o     = id_q;
   assign bus.stable_o = stable_q;

endmodule

// File: tb/tb_tt_bin_clock_btn_cond.sv
// Self-checking bench for the button conditioner: a scoreboard of expected
// pulses (edge number + id_o value) is filled as stimulus is driven and drained
// by a monitor that samples id_o on the falling clock edge.
module tb_tt_bin_clock_btn_cond;

   localparam int NP  = 3;
   localparam int DB  = 4;
   localparam int DLY = 10;
   localparam int PER = 3;
   localparam int LAT = DB + 2;   // input driven after edge N -> pulse after edge N+LAT

   typedef struct {
      int         edge_no;
      logic [5:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   edge_n = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];

   tt_bin_clock_btn_cond_if #(.NUM_PAIRS(NP)) bus ();

   tt_bin_clock_btn_cond #(
      .NUM_PAIRS (NP),
      .DB_CNT    (DB),
      .RPT_DELAY (DLY),
      .RPT_PERIOD(PER)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   // Scoreboard monitor: any nonzero id_o must match the oldest expected pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_pulse: got no pulse, expected id_o=%b after edge %0d",
                     exp_q[0].val, exp_q[0].edge_no);
            void'(exp_q.pop_front());
         end
         if (bus.id_o !== 6'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_pulse: got id_o=%b after edge %0d, expected none",
                        bus.id_o, edge_n);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (e.edge_no != edge_n || e.val !== bus.id_o) begin
                  n_err++;
                  $display("FAIL pulse: got id_o=%b after edge %0d, expected id_o=%b after edge %0d",
                           bus.id_o, edge_n, e.val, e.edge_no);
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_edge(input int e);
      while (edge_n < e) tick();
   endtask

   task automatic push(input int e, input logic [5:0] v);
      exp_t x;
      x.edge_no = e;
      x.val     = v;
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      int n;
      int r;
      bus.btn_i    = 6'h3F;
      bus.rpt_en_i = 1'b1;
      rst          = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         mon_en = 1'b1;
         n_cmp++;
         if (bus.id_o !== 6'b0 || bus.stable_o !== 6'b0) begin
            n_err++;
            $display("FAIL reset_hold: got id_o=%b stable_o=%b, expected 0/0",
                     bus.id_o, bus.stable_o);
         end
      end
      rst = 1'b0;
      n   = edge_n;
      wait_edge(n + LAT - 1);
      n_cmp++;
      if (bus.stable_o !== 6'h00) begin
         n_err++;
         $display("FAIL reset_stable_early: got stable_o=%h, expected 00", bus.stable_o);
      end
      wait_edge(n + LAT);
      n_cmp++;
      if (bus.stable_o !== 6'h3F) begin
         n_err++;
         $display("FAIL reset_stable_on: got stable_o=%h, expected 3f", bus.stable_o);
      end
      bus.btn_i = 6'h00;
      r = edge_n;
      wait_edge(r + LAT + 2);
      n_cmp++;
      if (bus.stable_o !== 6'h00 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_release: got stable_o=%h pending=%0d, expected 00/0",
                  bus.stable_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_clean_press();
      int n;
      int r;
      bus.rpt_en_i = 1'b0;
      tick();
      n = edge_n;
      push(n + LAT, 6'b100000);
      bus.btn_i[5] = 1'b1;
      wait_edge(n + 8);
      bus.btn_i[5] = 1'b0;
      r = edge_n;
      wait_edge(r + LAT + 4);
      n_cmp++;
      if (bus.stable_o !== 6'h00 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL clean_press_end: got stable_o=%h pending=%0d, expected 00/0",
                  bus.stable_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bounce();
      logic seq [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int   n;
      int   last_rise;
      bus.rpt_en_i = 1'b1;
      tick();
      n = edge_n;
      last_rise = 0;
      for (int i = 1; i < 10; i++) begin
         if (seq[i] && !seq[i-1]) last_rise = i;
      end
      push(n + last_rise + LAT, 6'b000100);
      for (int i = 0; i < 10; i++) begin
         bus.btn_i[2] = seq[i];
         n_cmp++;
         if (bus.stable_o[2] !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_stable_step%0d: got stable_o[2]=%b, expected 0", i, bus.stable_o[2]);
         end
         tick();
      end
      bus.btn_i[2] = 1'b0;
      wait_edge(n + last_rise + LAT);
      n_cmp++;
      if (bus.stable_o[2] !== 1'b1) begin
         n_err++;
         $display("FAIL bounce_stable_on: got stable_o[2]=%b, expected 1", bus.stable_o[2]);
      end
      wait_edge(n + 10 + LAT + 3);
      n_cmp++;
      if (bus.stable_o !== 6'h00 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bounce_end: got stable_o=%h pending=%0d, expected 00/0",
                  bus.stable_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_auto_repeat();
      int n;
      int r;
      int fall;
      bus.rpt_en_i = 1'b1;
      tick();
      n    = edge_n;
      r    = n + 30;
      fall = r + LAT;
      push(n + LAT, 6'b000010);
      for (int t = n + LAT + DLY; t < fall; t += PER) push(t, 6'b000010);
      bus.btn_i[1] = 1'b1;
      wait_edge(r);
      bus.btn_i[1] = 1'b0;
      wait_edge(fall + DLY + PER);
      n_cmp++;
      if (bus.stable_o !== 6'h00 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL auto_repeat_end: got stable_o=%h pending=%0d, expected 00/0",
                  bus.stable_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_conflict();
      int n;
      int r2;
      int f2;
      int r3;
      int f3;
      bus.rpt_en_i = 1'b1;
      tick();
      n  = edge_n;
      r2 = n + 15;
      f2 = r2 + LAT;
      r3 = f2 + 17;
      f3 = r3 + LAT;
      for (int t = f2 + DLY; t < f3; t += PER) push(t, 6'b001000);
      bus.btn_i[3:2] = 2'b11;
      wait_edge(n + LAT);
      n_cmp++;
      if (bus.stable_o[3:2] !== 2'b11) begin
         n_err++;
         $display("FAIL conflict_both_stable: got stable_o[3:2]=%b, expected 11", bus.stable_o[3:2]);
      end
      wait_edge(r2);
      bus.btn_i[2] = 1'b0;
      wait_edge(f2 - 1);
      n_cmp++;
      if (bus.stable_o[3:2] !== 2'b11) begin
         n_err++;
         $display("FAIL conflict_pre_fall: got stable_o[3:2]=%b, expected 11", bus.stable_o[3:2]);
      end
      wait_edge(f2);
      n_cmp++;
      if (bus.stable_o[3:2] !== 2'b10) begin
         n_err++;
         $display("FAIL conflict_fall: got stable_o[3:2]=%b, expected 10", bus.stable_o[3:2]);
      end
      wait_edge(r3);
      bus.btn_i[3] = 1'b0;
      wait_edge(f3 + DLY);
      n_cmp++;
      if (bus.stable_o !== 6'h00 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL conflict_end: got stable_o=%h pending=%0d, expected 00/0",
                  bus.stable_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid_hold();
      int n;
      int r;
      bus.rpt_en_i = 1'b1;
      tick();
      n = edge_n;
      push(n + LAT, 6'b000001);
      push(n + LAT + DLY, 6'b000001);
      push(n + LAT + DLY + PER, 6'b000001);
      bus.btn_i[0] = 1'b1;
      // Next repeat would land after edge n+LAT+DLY+2*PER; reset is sampled on exactly that edge.
      wait_edge(n + LAT + DLY + 2*PER - 1);
      rst = 1'b1;
      wait_edge(n + LAT + DLY + 2*PER);
      n_cmp++;
      if (bus.id_o[0] !== 1'b0 || bus.stable_o !== 6'h00) begin
         n_err++;
         $display("FAIL reset_mid_hold_kill: got id_o[0]=%b stable_o=%h, expected 0/00",
                  bus.id_o[0], bus.stable_o);
      end
      tick();
      rst = 1'b0;
      r = edge_n;
      push(r + LAT, 6'b000001);
      wait_edge(r + 8);
      bus.btn_i[0] = 1'b0;
      wait_edge(r + 8 + LAT + DLY);
      n_cmp++;
      if (bus.stable_o !== 6'h00 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_mid_hold_end: got stable_o=%h pending=%0d, expected 00/0",
                  bus.stable_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bus.rpt_en_i = 1'b0;
      tick();
      n = edge_n;
      push(n + LAT, 6'b100010);
      bus.btn_i = 6'b100010;
      wait_edge(n + 8);
      bus.btn_i = 6'b000000;
      wait_edge(n + 8 + LAT + 2);
      n_cmp++;
      if (bus.stable_o !== 6'h00 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL back_to_back_end: got stable_o=%h pending=%0d, expected 00/0",
                  bus.stable_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      bus.btn_i    = 6'h3F;
      bus.rpt_en_i = 1'b1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_conflict();
      test_reset_mid_hold();
      test_back_to_back();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "time limit");
   end

endmodule
